im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 20 ++
 rtl/im_loader_word_asm.sv | 46 ++++
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum stage is enabled by defining IM_LOADER_CHECKSUM_EN.
package im_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
`ifdef IM_LOADER_CHECKSUM_EN
    CSUM   = 3'd3,
`endif
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES    = 2;
  localparam int WORD_BYTES   = 4;
  localparam int IM_DEPTH_DEF = 1024;

endpackage

// File: rtl/im_loader_word_asm.sv
// Byte-to-word packer: the first byte of each group of four lands in the MSBs,
// and word_valid pulses for one cycle once the fourth byte has been taken.
module im_loader_word_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  in_data,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_r;
  logic [23:0] acc_r;
  logic [31:0] word_r;
  logic        valid_r;

  // shift in bytes, emit the assembled word on the last byte of the group
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_r <= 2'd0;
      acc_r      <= 24'd0;
      word_r     <= 32'd0;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (take) begin
        if (byte_cnt_r == 2'(WORD_BYTES - 1)) begin
          word_r     <= {acc_r, in_data};
          valid_r    <= 1'b1;
          byte_cnt_r <= 2'd0;
        end else begin
          acc_r      <= {acc_r[15:0], in_data};
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
      end
    end
  end

  assign byte_cnt   = byte_cnt_r;
  assign word       = word_r;
  assign word_valid = valid_r;

endmodule

// File: rtl/im_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the CPU in reset until done.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int mem_size = 16,
  parameter int IM_DEPTH = IM_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                im_we,
  output logic [mem_size-1:0] im_waddr,
  output logic [bit_size-1:0] im_wdata,
  output logic                cpu_rst,
  output logic                done,
  output logic                error
);

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif
  localparam logic [16:0] DEPTH_LIM = 17'(IM_DEPTH);

  state_t              state_r;
  state_t              next_s;
  logic                in_ready_r;
  logic                cpu_rst_r;
  logic                done_r;
  logic                error_r;
  logic [7:0]          hdr_hi_r;
  logic [15:0]         count_r;
  logic [15:0]         widx_r;
  logic [mem_size-1:0] waddr_r;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  logic        take_s;
  logic        asm_take_s;
  logic        word_last_s;
  logic [15:0] n_s;
  logic [1:0]  byte_cnt_s;
  logic [31:0] word_s;
  logic        word_valid_s;

  assign take_s      = in_valid & in_ready_r;
  assign asm_take_s  = take_s & (state_r == DATA);
  assign word_last_s = asm_take_s & (byte_cnt_s == 2'd3);
  assign n_s         = {hdr_hi_r, in_data};

  im_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .take       (asm_take_s),
    .in_data    (in_data),
    .byte_cnt   (byte_cnt_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // next-state decision from the current state and this cycle's transfer
  always_comb begin
    next_s = state_r;
    case (state_r)
      HDR_HI: begin
        if (take_s) next_s = HDR_LO;
        else        next_s = HDR_HI;
      end
      HDR_LO: begin
        if (!take_s)                       next_s = HDR_LO;
        else if (n_s == 16'd0)             next_s = AFTER_DATA;
        else if ({1'b0, n_s} > DEPTH_LIM)  next_s = ERR;
        else                               next_s = DATA;
      end
      DATA: begin
        if (word_last_s && (widx_r == count_r - 16'd1)) next_s = AFTER_DATA;
        else                                            next_s = DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (!take_s)                 next_s = CSUM;
        else if (in_data == csum_r)  next_s = DONE;
        else                         next_s = ERR;
      end
`endif
      DONE:    next_s = DONE;
      ERR:     next_s = ERR;
      default: next_s = ERR;
    endcase
  end

  // state, header capture, word addressing and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= HDR_HI;
      in_ready_r <= 1'b0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      hdr_hi_r   <= 8'd0;
      count_r    <= 16'd0;
      widx_r     <= 16'd0;
      waddr_r    <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      state_r    <= next_s;
      in_ready_r <= (next_s != DONE) && (next_s != ERR);
      // cpu_rst lags DONE by one cycle so the last write lands first
      cpu_rst_r  <= (state_r != DONE);
      done_r     <= done_r | (next_s == DONE);
      error_r    <= error_r | (next_s == ERR);
      if (take_s && (state_r == HDR_HI)) hdr_hi_r <= in_data;
      if (take_s && (state_r == HDR_LO)) count_r <= n_s;
      if (word_last_s) begin
        waddr_r <= mem_size'(widx_r);
        widx_r  <= widx_r + 16'd1;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      if (take_s && ((state_r == HDR_HI) || (state_r == HDR_LO) || (state_r == DATA)))
        csum_r <= csum_r ^ in_data;
`endif
    end
  end

  assign in_ready = in_ready_r;
  assign im_we    = word_valid_s;
  assign im_waddr = waddr_r;
  assign im_wdata = bit_size'(word_s);
  assign cpu_rst  = cpu_rst_r;
  assign done     = done_r;
  assign error    = error_r;

endmodule

// File: tb/tb_im_loader.sv
// Randomized + directed bench for im_loader, checked every cycle against a byte-count based reference model.
module tb_im_loader;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif
  localparam int IM_DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [15:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state: expected outputs after the most recent edge
  logic        m_ready = 1'b0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [31:0] m_data = 32'd0;
  logic        m_cpu = 1'b1;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [7:0]  got[$];
  logic [7:0]  stream[$];
  logic [47:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_of(input int upto);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < upto; i++) x ^= stream[i];
    return x;
  endfunction

  // Behaviour derived from how many bytes have been consumed so far.
  task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
    int k;
    int n;
    logic [7:0] x;
    if (!r) begin
      got.delete();
      m_ready = 1'b0; m_we = 1'b0; m_addr = 16'd0; m_data = 32'd0;
      m_cpu = 1'b1; m_done = 1'b0; m_err = 1'b0;
      return;
    end
    m_cpu = !m_done;
    m_we  = 1'b0;
    if (v && m_ready) begin
      got.push_back(d);
      k = got.size();
      n = (k >= 2) ? int'({got[0], got[1]}) : 0;
      if (k == 2) begin
        if (n > IM_DEPTH) m_err = 1'b1;
        else if (n == 0 && !CSUM_ON) m_done = 1'b1;
      end else if (k > 2 && k <= 2 + 4 * n) begin
        if ((k - 2) % 4 == 0) begin
          m_we   = 1'b1;
          m_addr = 16'((k - 2) / 4 - 1);
          m_data = {got[k-4], got[k-3], got[k-2], got[k-1]};
          if (k == 2 + 4 * n && !CSUM_ON) m_done = 1'b1;
        end
      end else if (CSUM_ON && k == 3 + 4 * n) begin
        x = 8'h00;
        for (int i = 0; i < k - 1; i++) x ^= got[i];
        if (x == got[k-1]) m_done = 1'b1;
        else m_err = 1'b1;
      end
    end
    m_ready = !(m_done || m_err);
  endtask

  // every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("im_we", 32'(im_we), 32'(m_we));
      chk("im_waddr", 32'(im_waddr), 32'(m_addr));
      chk("im_wdata", im_wdata, m_data);
      chk("cpu_rst", 32'(cpu_rst), 32'(m_cpu));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      if (im_we === 1'b1) wlog.push_back({im_waddr, im_wdata});
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [7:0] d);
    rst = r; in_valid = v; in_data = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    wlog.delete();
  endtask

  task automatic feed(input int mode, input int max_bytes, input int budget);
    int c = 0;
    bit v;
    logic [7:0] d;
    while (got.size() < max_bytes && !(m_done || m_err) && c < budget) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (v && got.size() < stream.size()) ? stream[got.size()] : 8'($urandom);
      cyc(1'b1, v, d);
      c++;
    end
    chk("feed_bound", 32'(c < budget), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cyc(1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    do_reset(3);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done_err", {30'd0, done, error}, 32'd0);
    chk("rst_waddr", 32'(im_waddr), 32'd0);

    // two-word image, constant valid
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    if (CSUM_ON) stream.push_back(8'h8B);
    cyc(1'b1, 1'b0, 8'h5A);
    feed(0, stream.size(), 100);
    idle(4);
    chk("c32_nwrites", wlog.size(), 32'd2);
    chk("c32_w0", wlog[0][31:0], 32'h20080005);
    chk("c32_a0", 32'(wlog[0][47:32]), 32'd0);
    chk("c32_w1", wlog[1][31:0], 32'hAC080000);
    chk("c32_a1", 32'(wlog[1][47:32]), 32'd1);
    chk("c32_done", {30'd0, done, cpu_rst}, 32'd2);

    // same image, valid toggling
    do_reset(2);
    feed(1, stream.size(), 100);
    idle(4);
    chk("c33_nwrites", wlog.size(), 32'd2);
    chk("c33_w0", wlog[0][31:0], 32'h20080005);
    chk("c33_w1", wlog[1][31:0], 32'hAC080000);
    chk("c33_done", 32'(done), 32'd1);

    // oversize header
    do_reset(2);
    stream = '{8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    feed(0, 2, 20);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'($urandom));
    chk("c34_err", {29'd0, error, in_ready, cpu_rst}, 32'h5);
    chk("c34_nwrites", wlog.size(), 32'd0);

    // reset mid-load, then a fresh one-word image
    do_reset(2);
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h99, 8'h88, 8'h77, 8'h66};
    feed(0, 8, 50);
    do_reset(2);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    if (CSUM_ON) stream.push_back(8'h09);
    feed(0, stream.size(), 50);
    idle(3);
    chk("c35_nwrites", wlog.size(), 32'd1);
    chk("c35_w0", wlog[0][31:0], 32'h12345678);
    chk("c35_a0", 32'(wlog[0][47:32]), 32'd0);
    chk("c35_done", 32'(done), 32'd1);

    if (CSUM_ON) begin
      do_reset(2);
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      feed(2, stream.size(), 100);
      idle(3);
      chk("c36_good", {30'd0, done, error}, 32'd2);
      do_reset(2);
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      feed(2, stream.size(), 100);
      idle(3);
      chk("c36_bad", {29'd0, done, error, cpu_rst}, 32'd3);
    end

    // empty image
    do_reset(2);
    stream = '{8'h00, 8'h00};
    if (CSUM_ON) stream.push_back(8'h00);
    feed(0, stream.size(), 20);
    idle(3);
    chk("n0_done", {30'd0, done, cpu_rst}, 32'd2);
    chk("n0_nwrites", wlog.size(), 32'd0);

    // largest legal image
    do_reset(2);
    stream = '{8'h04, 8'h00};
    for (int i = 0; i < 4 * IM_DEPTH; i++) stream.push_back(8'($urandom));
    if (CSUM_ON) stream.push_back(xor_of(stream.size()));
    feed(0, stream.size(), 5000);
    idle(3);
    chk("max_nwrites", wlog.size(), 32'd1024);
    chk("max_last_addr", 32'(wlog[1023][47:32]), 32'd1023);
    chk("max_done", 32'(done), 32'd1);

    // random images with random valid gaps and occasional bad checksums
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(0, 12);
      do_reset($urandom_range(1, 3));
      stream = '{8'(n >> 8), 8'(n)};
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
      if (CSUM_ON) begin
        if ($urandom_range(0, 3) == 0) stream.push_back(xor_of(stream.size()) ^ 8'($urandom_range(1, 255)));
        else stream.push_back(xor_of(stream.size()));
      end
      feed(2, stream.size(), 400);
      idle($urandom_range(2, 8));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
